// File: rtl/bft_leaf_endpoint_pkg.sv
// Shared flit layout and start-controller state encoding for the BFT leaf endpoint.
package bft_leaf_pkg;

  localparam int FLIT_W    = 49;
  localparam int VALID_BIT = 48;
  localparam int ADDR_HI   = 47;
  localparam int ADDR_LO   = 43;
  localparam int PORT_HI   = 42;
  localparam int PORT_LO   = 39;
  localparam int DATA_HI   = 31;
  localparam int DATA_LO   = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_RUN
  } start_state_e;

endpackage

// File: rtl/bft_leaf_endpoint_if.sv
// Network-side flit bus of one leaf: uplink toward the tree, downlink from it.
interface bft_leaf_endpoint_if;
  import bft_leaf_pkg::*;

  flit_t up_flit;
  logic  up_valid;
  logic  up_ready;
  flit_t net_flit;
  logic  net_valid;
  logic  net_ready;

  modport master (output up_flit, up_valid, net_ready,
                  input  up_ready, net_flit, net_valid);

  modport slave  (input  up_flit, up_valid, net_ready,
                  output up_ready, net_flit, net_valid);
endinterface

// File: rtl/bft_leaf_endpoint_fifo.sv
// Show-ahead synchronous FIFO; the caller only pushes when there is room (or a pop
// happens in the same cycle) and only pops when not empty.
module leaf_sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: the storage array is deliberately not reset; count alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/bft_leaf_endpoint.sv
// Network-side endpoint of one page leaf link: uplink buffer with resend, address-filtered
// downlink register, and the page ap_start generator. Optional drop counters: LEAF_STATS_EN.
module bft_leaf_endpoint
  import bft_leaf_pkg::*;
#(
  parameter logic [4:0] LEAF_ADDR   = 5'd0,
  parameter int         FIFO_DEPTH  = 8,
  parameter int         START_DELAY = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  flit_t                      dout_leaf_interface2bft,
  output flit_t                      din_leaf_bft2interface,
  output logic                       resend,
  output logic                       ap_start,
  bft_leaf_endpoint_if.master        net
`ifdef LEAF_STATS_EN
  ,
  output logic [15:0]                stat_drop_up,
  output logic [15:0]                stat_drop_dn
`endif
);

  localparam int CNT_W = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((START_DELAY == 0) ? 0 : START_DELAY - 1);

  logic                          fifo_full;
  logic                          fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          push_req;
  logic                          pop;
  logic                          accept;
  logic                          drop;
  logic                          net_hit;

  // A full buffer still takes a flit when the head leaves in the same cycle.
  assign push_req     = dout_leaf_interface2bft[VALID_BIT];
  assign pop          = !fifo_empty && net.up_ready;
  assign accept       = push_req && (!fifo_full || pop);
  assign drop         = push_req && !accept;
  assign net.up_valid = (fifo_count != '0);

  leaf_sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_up_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (accept),
    .pop     (pop),
    .wr_data (dout_leaf_interface2bft),
    .rd_data (net.up_flit),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign net_hit = net.net_valid && net.net_flit[VALID_BIT]
                && (net.net_flit[ADDR_HI:ADDR_LO] == LEAF_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      din_leaf_bft2interface <= '0;
      resend                 <= 1'b0;
      net.net_ready          <= 1'b0;
    end else begin
      din_leaf_bft2interface <= net_hit ? net.net_flit : '0;
      resend                 <= drop;
      net.net_ready          <= 1'b1;
    end
  end

  start_state_e     state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ap_start <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (START_DELAY == 0) begin
            state    <= ST_RUN;
            ap_start <= 1'b1;
          end else begin
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (cnt == CNT_LAST) begin
            state    <= ST_RUN;
            ap_start <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN:  ap_start <= 1'b1;
        default: state    <= ST_IDLE;
      endcase
    end
  end

`ifdef LEAF_STATS_EN
  logic net_miss;
  assign net_miss = net.net_valid && net.net_flit[VALID_BIT]
                 && (net.net_flit[ADDR_HI:ADDR_LO] != LEAF_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_drop_up <= '0;
      stat_drop_dn <= '0;
    end else begin
      if (drop && stat_drop_up != 16'hFFFF)     stat_drop_up <= stat_drop_up + 1'b1;
      if (net_miss && stat_drop_dn != 16'hFFFF) stat_drop_dn <= stat_drop_dn + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bft_leaf_endpoint.sv
// Scoreboard bench for bft_leaf_endpoint: uplink flits are queued as they are accepted by a
// reference occupancy model and compared when the network pops them.
module tb_bft_leaf_endpoint;
  import bft_leaf_pkg::*;

  localparam int DEPTH = 8;
  localparam int DELAY = 16;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  flit_t dout_leaf_interface2bft;
  flit_t din_leaf_bft2interface;
  logic  resend;
  logic  ap_start;
`ifdef LEAF_STATS_EN
  logic [15:0] stat_drop_up;
  logic [15:0] stat_drop_dn;
`endif

  bft_leaf_endpoint_if net_bus ();

  bft_leaf_endpoint #(
    .LEAF_ADDR   (5'd0),
    .FIFO_DEPTH  (DEPTH),
    .START_DELAY (DELAY)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .dout_leaf_interface2bft (dout_leaf_interface2bft),
    .din_leaf_bft2interface  (din_leaf_bft2interface),
    .resend                  (resend),
    .ap_start                (ap_start),
    .net                     (net_bus)
`ifdef LEAF_STATS_EN
    ,
    .stat_drop_up            (stat_drop_up),
    .stat_drop_dn            (stat_drop_dn)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  flit_t sb[$];
  int    since_rst = 0;
  int    exp_up_drops = 0;
  int    exp_dn_drops = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic flit_t mk(input logic [4:0] dest, input logic [3:0] port, input logic [31:0] data);
    return {1'b1, dest, port, 7'h5A, data};
  endfunction

  // Called in the low phase; drives one cycle of stimulus and returns at the next negedge.
  task automatic cycle(input flit_t up_in, input logic rdy, input flit_t nf, input logic nv);
    logic  pop_m, acc_m, exp_resend;
    flit_t exp_din;
    dout_leaf_interface2bft = up_in;
    net_bus.up_ready        = rdy;
    net_bus.net_flit        = nf;
    net_bus.net_valid       = nv;
    #1;
    pop_m = (sb.size() != 0) && rdy;
    acc_m = up_in[VALID_BIT] && ((sb.size() < DEPTH) || pop_m);
    check_eq("up_valid", 64'(net_bus.up_valid), 64'(sb.size() != 0));
    if (pop_m) begin
      check_eq("up_flit", 64'(net_bus.up_flit), 64'(sb[0]));
      void'(sb.pop_front());
    end
    if (acc_m) sb.push_back(up_in);
    exp_resend = up_in[VALID_BIT] && !acc_m;
    if (exp_resend) exp_up_drops++;
    exp_din = '0;
    if (nv && nf[VALID_BIT]) begin
      if (nf[ADDR_HI:ADDR_LO] == 5'd0) exp_din = nf;
      else                             exp_dn_drops++;
    end
    @(posedge clk);
    #1;
    check_eq("resend", 64'(resend), 64'(exp_resend));
    check_eq("din_leaf", 64'(din_leaf_bft2interface), 64'(exp_din));
    check_eq("net_ready", 64'(net_bus.net_ready), 64'd1);
    check_eq("ap_start", 64'(ap_start), 64'(since_rst >= DELAY));
    since_rst++;
`ifdef LEAF_STATS_EN
    check_eq("stat_drop_up", 64'(stat_drop_up), 64'(exp_up_drops));
    check_eq("stat_drop_dn", 64'(stat_drop_dn), 64'(exp_dn_drops));
`endif
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle('0, rdy, '0, 1'b0);
  endtask

  // Asserts reset away from any clock edge, checks the reset state, releases at a negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_eq("rst_up_valid", 64'(net_bus.up_valid), 64'd0);
    check_eq("rst_resend", 64'(resend), 64'd0);
    check_eq("rst_ap_start", 64'(ap_start), 64'd0);
    check_eq("rst_din_leaf", 64'(din_leaf_bft2interface), 64'd0);
    check_eq("rst_net_ready", 64'(net_bus.net_ready), 64'd0);
`ifdef LEAF_STATS_EN
    check_eq("rst_stat_up", 64'(stat_drop_up), 64'd0);
    check_eq("rst_stat_dn", 64'(stat_drop_dn), 64'd0);
`endif
    sb.delete();
    since_rst    = 0;
    exp_up_drops = 0;
    exp_dn_drops = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    dout_leaf_interface2bft = '0;
    net_bus.up_ready        = 1'b0;
    net_bus.net_flit        = '0;
    net_bus.net_valid       = 1'b0;
    @(negedge clk);
    do_reset();

    // Start delay, then a reset in the middle of counting restarts it.
    idle(20, 1'b0);
    do_reset();
    idle(8, 1'b0);
    do_reset();
    idle(20, 1'b0);

    // Three flits drain in order with the network always ready.
    cycle(mk(5'd1, 4'd0, 32'h11), 1'b1, '0, 1'b0);
    cycle(mk(5'd1, 4'd0, 32'h22), 1'b1, '0, 1'b0);
    cycle(mk(5'd1, 4'd0, 32'h33), 1'b1, '0, 1'b0);
    idle(3, 1'b1);

    // Nine pushes into a stalled buffer: the ninth is dropped, then eight drain.
    for (int i = 0; i < 9; i++) cycle(mk(5'd2, 4'd1, 32'h100 + i), 1'b0, '0, 1'b0);
    cycle(mk(5'd2, 4'd1, 32'h1FF) & ~(flit_t'(1) << VALID_BIT), 1'b0, '0, 1'b0);
    idle(10, 1'b1);

    // Full buffer with a simultaneous push and pop.
    for (int i = 0; i < 8; i++) cycle(mk(5'd3, 4'd2, 32'h200 + i), 1'b0, '0, 1'b0);
    cycle(mk(5'd3, 4'd2, 32'h2AA), 1'b1, '0, 1'b0);
    cycle(mk(5'd3, 4'd2, 32'h2BB), 1'b0, '0, 1'b0);
    idle(10, 1'b1);

    // Downlink address filtering.
    cycle('0, 1'b1, mk(5'd0, 4'd3, 32'hDEADBEEF), 1'b1);
    cycle('0, 1'b1, mk(5'd5, 4'd3, 32'hCAFEF00D), 1'b1);
    cycle('0, 1'b1, mk(5'd0, 4'd7, 32'h12345678), 1'b0);
    cycle('0, 1'b1, mk(5'd0, 4'd7, 32'h12345678) & ~(flit_t'(1) << VALID_BIT), 1'b1);
    cycle('0, 1'b1, mk(5'd0, 4'd9, 32'h0BADC0DE), 1'b1);

    // Reset with four flits buffered discards them silently.
    for (int i = 0; i < 4; i++) cycle(mk(5'd4, 4'd0, 32'h300 + i), 1'b0, '0, 1'b0);
    do_reset();
    idle(4, 1'b1);

    // Random traffic on both directions.
    for (int i = 0; i < 300; i++) begin
      flit_t up_f, dn_f;
      up_f = mk(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 3) == 0) up_f[VALID_BIT] = 1'b0;
      dn_f = mk(($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                4'($urandom_range(0, 15)), $urandom);
      cycle(up_f, ($urandom_range(0, 2) == 0), dn_f, ($urandom_range(0, 1) == 1));
    end
    idle(12, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
